conv_mem_responder: RTL and testbench
=====================================

Name: conv_mem_responder

Overview:
- Synthesizable responder for the CONV accelerator's memory-side interface: image ROM (iaddr/idata), layer memories selected by csel (crd/cwr), and the ready/busy start handshake.
- A host port loads the 64x64 input image, launches CONV, then reads back layer results after CONV drops busy.
- Sits between CONV and the system/host bus; it replaces the behavioural memory model for FPGA/emulation runs.

Parameters:
- DATA_W, 20, pixel/data word width
- ADDR_W, 12, address width for all ports
- L0_DEPTH, 4096, depth of the image memory and each layer-0 bank
- L1_DEPTH, 1024, depth of each layer-1 bank
- L2_DEPTH, 2048, depth of the layer-2 bank

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- host_we  in  1  write the image word (honoured in IDLE only)
- host_addr  in  ADDR_W  image write address
- host_wdata  in  DATA_W  image write data
- host_start  in  1  launch request
- host_rd  in  1  readback request (honoured in DONE only)
- host_rsel  in  3  readback bank, same encoding as csel
- host_raddr  in  ADDR_W  readback address
- host_rdata  out  DATA_W  readback data
- host_rvalid  out  1  one-cycle pulse qualifying host_rdata
- done  out  1  CONV finished, results readable
- err  out  1  sticky protocol-error flag
- ready  out  1  start request to CONV
- busy  in  1  CONV busy
- iaddr  in  ADDR_W  image read address
- idata  out  DATA_W  image read data
- cwr  in  1  layer write strobe
- caddr_wr  in  ADDR_W  layer write address
- cdata_wr  in  DATA_W  layer write data
- crd  in  1  layer read strobe
- caddr_rd  in  ADDR_W  layer read address
- cdata_rd  out  DATA_W  layer read data
- csel  in  3  bank select

Behaviour:
- Bank encoding: 001 = L0 kernel0, 010 = L0 kernel1, 011 = L1 kernel0, 100 = L1 kernel1, 101 = L2. Codes 000, 110 and 111 are illegal.
- Reset (reset=0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Memory arrays are not cleared; their contents are undefined after reset.
- FSM:
  - IDLE: host_we writes the image memory. host_start moves to ARM.
  - ARM: ready=1. When busy is sampled 1, go to RUN; ready=0 from the next cycle.
  - RUN: wait for busy sampled 0, then go to DONE.
  - DONE: done=1 and host readback is enabled. host_start clears done and returns to IDLE. Image and layer contents persist.
- idata:
  - Registered, 1-cycle latency: iaddr sampled at edge N gives image[iaddr] valid after edge N, in ARM and RUN.
  - idata=0 in IDLE and DONE.
- cwr:
  - Honoured only in RUN; writes bank[csel][caddr_wr] at the edge.
  - cwr outside RUN: the write is dropped and err is set.
- crd:
  - At the edge, cdata_rd <= bank[csel][caddr_rd], so data is valid the following cycle.
  - cdata_rd holds its value when crd=0.
- Same edge, cwr and crd to the same bank and address: read returns the old data (read-before-write).
- Illegal csel with cwr or crd: no write, cdata_rd <= 0, err set.
- Address at or above the bank depth (L1 >= 1024, L2 >= 2048) on a CONV or host access: write dropped, read returns 0, err set. Addresses never wrap.
- Host readback:
  - host_rd in DONE gives host_rdata = bank[host_rsel][host_raddr] and host_rvalid=1 on the next cycle.
  - host_rd in any other state is ignored; host_rvalid stays 0.
- host_we outside IDLE is ignored and err is set.
- err is sticky: it clears only on reset or on host_start taken from DONE.
- host_start in ARM or RUN is ignored.
- busy dropping in ARM, before it was ever seen high, has no effect; the FSM stays in ARM.

Test Plan:
- Reset mid-RUN: reset=0 while in RUN -> ready=0, done=0, idata=0, err=0 immediately; FSM in IDLE after reset releases.
- Load and handshake: load image[k]=k for all k; host_start; busy rises 2 cycles later -> ready=1 through the cycle busy is sampled high, ready=0 the cycle after; iaddr=0x0A5 -> idata=0x000A5 on the next cycle.
- Layer writes and readback: in RUN, cwr csel=001 addr 0x123 data 0xABCDE, and csel=101 addr 0x7FF data 0x00042; drop busy -> done=1; host_rd rsel=001 raddr=0x123 -> host_rdata=0xABCDE with host_rvalid=1 one cycle later; rsel=101 raddr=0x7FF -> 0x00042.
- Read-before-write: L1 kernel0 addr 5 holds 0x00011; same edge cwr data 0x00022 and crd addr 5, csel=011 -> cdata_rd=0x00011; next crd -> 0x00022.
- Errors: cwr csel=110 -> no bank changes, err=1. crd csel=100 addr 0x400 -> cdata_rd=0, err stays 1. host_start from DONE -> err=0.
- Ignored requests: host_rd during RUN -> host_rvalid stays 0; host_we during DONE -> image unchanged, err=1.

Source files
------------

// File: rtl/conv_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : conv_mem_responder
//  Purpose  : Memory-side responder for the CONV accelerator. Holds the
//             64x64 input image and the five layer banks, drives the
//             ready/busy start handshake and offers a host port for image
//             load, launch and result readback.
//  Ports    : clk, reset (async, active-low)
//             host_we/host_addr/host_wdata  - image load (IDLE only)
//             host_start                    - launch / acknowledge done
//             host_rd/host_rsel/host_raddr  - readback request (DONE only)
//             host_rdata/host_rvalid        - readback data + 1-cycle valid
//             done, err                     - status (err is sticky)
//             ready/busy                    - CONV start handshake
//             iaddr/idata                   - image ROM port (1-cycle latency)
//             cwr/caddr_wr/cdata_wr         - layer write port
//             crd/caddr_rd/cdata_rd         - layer read port
//             csel                          - layer bank select
//  Revision : 1.0 - initial release
// ============================================================================
module conv_mem_responder #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 12,
  parameter int L0_DEPTH = 4096,
  parameter int L1_DEPTH = 1024,
  parameter int L2_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_start,
  input  logic              host_rd,
  input  logic [2:0]        host_rsel,
  input  logic [ADDR_W-1:0] host_raddr,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              done,
  output logic              err,
  output logic              ready,
  input  logic              busy,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] idata,
  input  logic              cwr,
  input  logic [ADDR_W-1:0] caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic              crd,
  input  logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_rd,
  input  logic [2:0]        csel
);

  localparam int c_L0_AW = $clog2(L0_DEPTH);
  localparam int c_L1_AW = $clog2(L1_DEPTH);
  localparam int c_L2_AW = $clog2(L2_DEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ARM  = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [2:0] c_SEL_L0K0 = 3'b001;
  localparam logic [2:0] c_SEL_L0K1 = 3'b010;
  localparam logic [2:0] c_SEL_L1K0 = 3'b011;
  localparam logic [2:0] c_SEL_L1K1 = 3'b100;
  localparam logic [2:0] c_SEL_L2   = 3'b101;

  // Storage is never reset; contents are undefined after power-up.
  logic [DATA_W-1:0] r_mem_img  [L0_DEPTH];
  logic [DATA_W-1:0] r_mem_l0k0 [L0_DEPTH];
  logic [DATA_W-1:0] r_mem_l0k1 [L0_DEPTH];
  logic [DATA_W-1:0] r_mem_l1k0 [L1_DEPTH];
  logic [DATA_W-1:0] r_mem_l1k1 [L1_DEPTH];
  logic [DATA_W-1:0] r_mem_l2   [L2_DEPTH];

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_err;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_host_rdata;
  logic [DATA_W-1:0] r_idata;
  logic [DATA_W-1:0] r_cdata_rd;

  logic              w_cwr_ok;
  logic              w_crd_ok;
  logic              w_hrd_ok;
  logic              w_img_ok;
  logic              w_cwr_en;
  logic              w_img_we;
  logic              w_err_set;
  logic              w_err_clr;
  logic [DATA_W-1:0] w_crd_data;
  logic [DATA_W-1:0] w_hrd_data;

  // Legal bank code with an address inside that bank; addresses never wrap.
  function automatic logic f_addr_ok(input logic [2:0] sel, input logic [ADDR_W-1:0] addr);
    case (sel)
      c_SEL_L0K0, c_SEL_L0K1: f_addr_ok = (32'(addr) < 32'(L0_DEPTH));
      c_SEL_L1K0, c_SEL_L1K1: f_addr_ok = (32'(addr) < 32'(L1_DEPTH));
      c_SEL_L2:               f_addr_ok = (32'(addr) < 32'(L2_DEPTH));
      default:                f_addr_ok = 1'b0;
    endcase
  endfunction

  assign w_cwr_ok = f_addr_ok(csel, caddr_wr);
  assign w_crd_ok = f_addr_ok(csel, caddr_rd);
  assign w_hrd_ok = f_addr_ok(host_rsel, host_raddr);
  assign w_img_ok = (32'(host_addr) < 32'(L0_DEPTH));

  assign w_cwr_en = cwr && (r_state == c_RUN) && w_cwr_ok;
  assign w_img_we = host_we && (r_state == c_IDLE) && w_img_ok;

  assign w_err_set = (cwr && ((r_state != c_RUN) || !w_cwr_ok))
                   | (crd && !w_crd_ok)
                   | (host_we && ((r_state != c_IDLE) || !w_img_ok))
                   | (host_rd && (r_state == c_DONE) && !w_hrd_ok);
  assign w_err_clr = host_start && (r_state == c_DONE);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: if (host_start) w_state_next = c_ARM;
      c_ARM:  if (busy)       w_state_next = c_RUN;
      c_RUN:  if (!busy)      w_state_next = c_DONE;
      c_DONE: if (host_start) w_state_next = c_IDLE;
      default:                w_state_next = c_IDLE;
    endcase
  end

  // ------------------------------------------------------- read muxes
  always_comb begin
    w_crd_data = '0;
    case (csel)
      c_SEL_L0K0: w_crd_data = r_mem_l0k0[caddr_rd[c_L0_AW-1:0]];
      c_SEL_L0K1: w_crd_data = r_mem_l0k1[caddr_rd[c_L0_AW-1:0]];
      c_SEL_L1K0: w_crd_data = r_mem_l1k0[caddr_rd[c_L1_AW-1:0]];
      c_SEL_L1K1: w_crd_data = r_mem_l1k1[caddr_rd[c_L1_AW-1:0]];
      c_SEL_L2:   w_crd_data = r_mem_l2[caddr_rd[c_L2_AW-1:0]];
      default:    w_crd_data = '0;
    endcase
  end

  always_comb begin
    w_hrd_data = '0;
    case (host_rsel)
      c_SEL_L0K0: w_hrd_data = r_mem_l0k0[host_raddr[c_L0_AW-1:0]];
      c_SEL_L0K1: w_hrd_data = r_mem_l0k1[host_raddr[c_L0_AW-1:0]];
      c_SEL_L1K0: w_hrd_data = r_mem_l1k0[host_raddr[c_L1_AW-1:0]];
      c_SEL_L1K1: w_hrd_data = r_mem_l1k1[host_raddr[c_L1_AW-1:0]];
      c_SEL_L2:   w_hrd_data = r_mem_l2[host_raddr[c_L2_AW-1:0]];
      default:    w_hrd_data = '0;
    endcase
  end

  // ------------------------------------------------------ control regs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_IDLE;
      r_err         <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
      r_idata       <= '0;
      r_cdata_rd    <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= (r_err & ~w_err_clr) | w_err_set;

      // Keyed on the next state so idata is already zero in the first
      // DONE cycle and already live in the first ARM cycle.
      if ((w_state_next == c_ARM) || (w_state_next == c_RUN))
        r_idata <= r_mem_img[iaddr[c_L0_AW-1:0]];
      else
        r_idata <= '0;

      // Non-blocking read of the array gives read-before-write on a
      // same-edge write to the same location.
      if (crd)
        r_cdata_rd <= w_crd_ok ? w_crd_data : '0;

      if (host_rd && (r_state == c_DONE)) begin
        r_host_rvalid <= 1'b1;
        r_host_rdata  <= w_hrd_ok ? w_hrd_data : '0;
      end else begin
        r_host_rvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------- memory writes
  always_ff @(posedge clk) begin
    if (w_img_we)
      r_mem_img[host_addr[c_L0_AW-1:0]] <= host_wdata;
  end

  always_ff @(posedge clk) begin
    if (w_cwr_en && (csel == c_SEL_L0K0))
      r_mem_l0k0[caddr_wr[c_L0_AW-1:0]] <= cdata_wr;
  end

  always_ff @(posedge clk) begin
    if (w_cwr_en && (csel == c_SEL_L0K1))
      r_mem_l0k1[caddr_wr[c_L0_AW-1:0]] <= cdata_wr;
  end

  always_ff @(posedge clk) begin
    if (w_cwr_en && (csel == c_SEL_L1K0))
      r_mem_l1k0[caddr_wr[c_L1_AW-1:0]] <= cdata_wr;
  end

  always_ff @(posedge clk) begin
    if (w_cwr_en && (csel == c_SEL_L1K1))
      r_mem_l1k1[caddr_wr[c_L1_AW-1:0]] <= cdata_wr;
  end

  always_ff @(posedge clk) begin
    if (w_cwr_en && (csel == c_SEL_L2))
      r_mem_l2[caddr_wr[c_L2_AW-1:0]] <= cdata_wr;
  end

  // ------------------------------------------------------------ outputs
  assign ready       = (r_state == c_ARM);
  assign done        = (r_state == c_DONE);
  assign err         = r_err;
  assign idata       = r_idata;
  assign cdata_rd    = r_cdata_rd;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_mem_responder
//  Purpose  : Self-checking bench for conv_mem_responder. Directed steps plus
//             randomized layer traffic compared against a bank-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_we;
  logic [11:0] host_addr;
  logic [19:0] host_wdata;
  logic        host_start;
  logic        host_rd;
  logic [2:0]  host_rsel;
  logic [11:0] host_raddr;
  logic [19:0] host_rdata;
  logic        host_rvalid;
  logic        done;
  logic        err;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;

  conv_mem_responder dut (
    .clk(clk), .reset(reset),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_start(host_start), .host_rd(host_rd), .host_rsel(host_rsel),
    .host_raddr(host_raddr), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .done(done), .err(err), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
  );

  always #5 clk = ~clk;

  // Reference model: image plus five banks, each with its own depth.
  logic [19:0] m_img  [4096];
  logic [19:0] m_bank [1:5][4096];
  int          wq[$];            // written locations, encoded sel*4096+addr
  logic [19:0] exp_cd;
  logic [19:0] exp_img;
  int          n_vec = 0;
  int          n_mis = 0;

  function automatic int bank_depth(input int sel);
    if (sel <= 2) return 4096;
    if (sel <= 4) return 1024;
    return 2048;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; host_we = 0; host_addr = '0; host_wdata = '0; host_start = 0;
    host_rd = 0; host_rsel = '0; host_raddr = '0; busy = 0; iaddr = '0;
    cwr = 0; caddr_wr = '0; cdata_wr = '0; crd = 0; caddr_rd = '0; csel = '0;
    exp_cd = '0;

    // ---- reset state
    tick(); tick();
    check("rst_ready", 32'(ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_idata", 32'(idata), 0);
    check("rst_cdata", 32'(cdata_rd), 0);
    check("rst_rvalid", 32'(host_rvalid), 0);
    reset = 1'b1;
    tick();

    // ---- reset mid-RUN, with err set beforehand
    host_start = 1; tick(); host_start = 0;
    busy = 1; tick();
    host_we = 1; host_addr = 12'h010; host_wdata = 20'h12345; tick(); host_we = 0;
    check("run_we_err", 32'(err), 1);
    #2 reset = 1'b0;
    #1;
    check("amid_ready", 32'(ready), 0);
    check("amid_done", 32'(done), 0);
    check("amid_idata", 32'(idata), 0);
    check("amid_err", 32'(err), 0);
    busy = 0;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_ready", 32'(ready), 0);

    // ---- load image[k] = k (only legal in IDLE, so err staying 0 proves IDLE)
    for (int k = 0; k < 4096; k++) begin
      host_we = 1; host_addr = 12'(k); host_wdata = 20'(k);
      m_img[k] = 20'(k);
      tick();
    end
    host_we = 0;
    check("load_err", 32'(err), 0);

    // ---- handshake
    host_start = 1; tick(); host_start = 0;
    check("arm_ready", 32'(ready), 1);
    iaddr = 12'h0A5; busy = 0; tick();
    check("arm_idata", 32'(idata), 32'h000A5);
    check("arm_nobusy_ready", 32'(ready), 1);
    busy = 1; #1;
    check("arm_busyhi_ready", 32'(ready), 1);
    tick();
    check("run_ready", 32'(ready), 0);

    // ---- directed layer writes
    cwr = 1; csel = 3'b001; caddr_wr = 12'h123; cdata_wr = 20'hABCDE; tick();
    m_bank[1][12'h123] = 20'hABCDE; wq.push_back(1*4096 + 12'h123);
    csel = 3'b101; caddr_wr = 12'h7FF; cdata_wr = 20'h00042; tick();
    m_bank[5][12'h7FF] = 20'h00042; wq.push_back(5*4096 + 12'h7FF);

    // ---- read-before-write on L1 kernel0 addr 5
    csel = 3'b011; caddr_wr = 12'd5; cdata_wr = 20'h00011; tick();
    cdata_wr = 20'h00022; crd = 1; caddr_rd = 12'd5; tick();
    check("rbw_old", 32'(cdata_rd), 32'h00011);
    cwr = 0; tick();
    check("rbw_new", 32'(cdata_rd), 32'h00022);
    crd = 0;
    m_bank[3][5] = 20'h00022; wq.push_back(3*4096 + 5);
    exp_cd = 20'h00022;

    // ---- randomized legal layer traffic in RUN
    for (int i = 0; i < 80; i++) begin
      int e, sel, raddr, waddr;
      logic [19:0] wdat;
      bit do_wr, do_rd;
      do_rd = 1'($urandom_range(0, 1));
      do_wr = 1'($urandom_range(0, 1));
      e     = wq[$urandom_range(0, wq.size() - 1)];
      sel   = e / 4096;
      raddr = e % 4096;
      if (!do_rd) sel = $urandom_range(1, 5);
      waddr = $urandom_range(0, bank_depth(sel) - 1);
      wdat  = 20'($urandom);
      csel = 3'(sel); cwr = do_wr; caddr_wr = 12'(waddr); cdata_wr = wdat;
      crd = do_rd; caddr_rd = 12'(raddr); iaddr = 12'($urandom_range(0, 4095));
      exp_img = m_img[iaddr];
      if (do_rd) exp_cd = m_bank[sel][raddr];
      tick();
      if (do_wr) begin
        m_bank[sel][waddr] = wdat;
        wq.push_back(sel * 4096 + waddr);
      end
      check("rnd_cdata", 32'(cdata_rd), 32'(exp_cd));
      check("rnd_idata", 32'(idata), 32'(exp_img));
    end
    cwr = 0; crd = 0;
    check("legal_err", 32'(err), 0);

    // ---- host_rd during RUN is ignored
    host_rd = 1; host_rsel = 3'b001; host_raddr = 12'h123; tick(); host_rd = 0;
    check("run_rd_rvalid", 32'(host_rvalid), 0);

    // ---- protocol errors
    cwr = 1; csel = 3'b110; caddr_wr = 12'h123; cdata_wr = 20'h55555; tick(); cwr = 0;
    check("badsel_err", 32'(err), 1);
    crd = 1; csel = 3'b100; caddr_rd = 12'h400; tick(); crd = 0;
    check("oob_cdata", 32'(cdata_rd), 0);
    check("oob_err", 32'(err), 1);

    // ---- finish run
    busy = 0; tick();
    check("done_flag", 32'(done), 1);
    check("done_idata", 32'(idata), 0);

    host_rd = 1; host_rsel = 3'b001; host_raddr = 12'h123; tick();
    check("rb1_rvalid", 32'(host_rvalid), 1);
    check("rb1_rdata", 32'(host_rdata), 32'hABCDE);
    host_rd = 0; tick();
    check("rb_pulse", 32'(host_rvalid), 0);
    host_rd = 1; host_rsel = 3'b101; host_raddr = 12'h7FF; tick(); host_rd = 0;
    check("rb2_rdata", 32'(host_rdata), 32'h00042);

    for (int i = 0; i < 12; i++) begin
      int e;
      e = wq[$urandom_range(0, wq.size() - 1)];
      host_rd = 1; host_rsel = 3'(e / 4096); host_raddr = 12'(e % 4096);
      tick();
      check("rnd_rvalid", 32'(host_rvalid), 1);
      check("rnd_rdata", 32'(host_rdata), 32'(m_bank[e / 4096][e % 4096]));
    end
    host_rd = 0;

    // ---- host_we in DONE ignored, then clear via host_start
    host_we = 1; host_addr = 12'h0A5; host_wdata = 20'hFFFFF; tick(); host_we = 0;
    check("done_we_err", 32'(err), 1);
    host_start = 1; tick(); host_start = 0;
    check("clr_err", 32'(err), 0);
    check("clr_done", 32'(done), 0);

    // ---- cwr outside RUN is dropped and flagged; err survives IDLE->ARM
    cwr = 1; csel = 3'b001; caddr_wr = 12'h123; cdata_wr = 20'h00000; tick(); cwr = 0;
    check("idle_cwr_err", 32'(err), 1);
    host_start = 1; iaddr = 12'h0A5; tick(); host_start = 0;
    check("sticky_err", 32'(err), 1);
    check("img_unchanged", 32'(idata), 32'h000A5);
    busy = 1; tick();
    busy = 0; tick();
    check("done2", 32'(done), 1);
    host_rd = 1; host_rsel = 3'b001; host_raddr = 12'h123; tick();
    check("cwr_dropped", 32'(host_rdata), 32'hABCDE);
    host_rsel = 3'b011; host_raddr = 12'h400; tick(); host_rd = 0;
    check("rb_oob_rvalid", 32'(host_rvalid), 1);
    check("rb_oob_rdata", 32'(host_rdata), 0);
    host_start = 1; tick(); host_start = 0;
    check("final_err", 32'(err), 0);
    check("final_done", 32'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
